// File: rtl/data_mem_responder_pkg.sv
// Shared types for the data memory responder: FSM state encoding, access opcode
// and the reset value of the hardware minimum tracker.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_t;

    localparam logic [31:0] INT32_MAX = 32'h7FFF_FFFF;

endpackage

// File: rtl/data_mem_responder_if.sv
// CPU data port bundle between the CPU (master) and the memory responder (slave).
interface data_mem_responder_if;

    // Handshake: the master holds mem_read/mem_write (plus data_adr/data_in) as a
    // request level; the slave samples it only while idle and answers with a single
    // mem_ready pulse. The master must drop the request by the cycle after that
    // pulse, or the held request is accepted again as a new access.
    logic [31:0] data_adr;
    logic [31:0] data_in;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] data_out;
    logic        mem_ready;
    logic        mem_err;

    modport master (
        output data_adr, data_in, mem_read, mem_write,
        input  data_out, mem_ready, mem_err
    );

    modport slave (
        input  data_adr, data_in, mem_read, mem_write,
        output data_out, mem_ready, mem_err
    );

endinterface

// File: rtl/data_mem_responder_min_tracker.sv
// Running signed minimum over committed writes that land in the tracked window
// [MIN_BASE, MIN_BASE + 4*MIN_COUNT); ties keep the earlier index.
module min_tracker
    import mem_pkg::*;
#(
    parameter logic [31:0] MIN_BASE  = 32'd1000,
    parameter int          MIN_COUNT = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [31:0] wr_adr,
    input  logic [31:0] wr_data,
    output logic [31:0] min_value,
    output logic [31:0] min_index
);

    localparam logic [31:0] MIN_END = MIN_BASE + 32'(4 * MIN_COUNT);

    logic hit;

    assign hit = wr_en && (wr_adr >= MIN_BASE) && (wr_adr < MIN_END);

    always_ff @(posedge clk) begin
        if (!rst) begin
            min_value <= INT32_MAX;
            min_index <= 32'd0;
        end else if (hit && ($signed(wr_data) < $signed(min_value))) begin
            min_value <= wr_data;
            min_index <= (wr_adr - MIN_BASE) >> 2;
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the CPU data port with LATENCY wait states per access.
// Define MIN_TRACK_EN to report a hardware-tracked minimum instead of software results.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int          DEPTH       = 1024,
    parameter int          LATENCY     = 2,
    parameter logic [31:0] MIN_BASE    = 32'd1000,
    parameter int          MIN_COUNT   = 20,
    parameter logic [31:0] MIN_RES_ADR = 32'd2000
) (
    input  logic                 clk,
    input  logic                 rst,
    data_mem_responder_if.slave  bus,
    output logic [31:0]          min_value,
    output logic [31:0]          min_index,
    output state_t               fsm_state
);

    localparam int AW = $clog2(DEPTH);

    state_t        state;
    state_t        state_next;
    logic [3:0]    cnt;
    logic [31:0]   adr_q;
    logic [31:0]   wdata_q;
    op_t           op_q;
    logic [31:0]   data_q;
    logic          err_q;
    logic [31:0]   mem [DEPTH];
    logic          req;
    logic          req_err;
    logic          in_range;
    logic          commit;
    logic          commit_wr;
    logic [AW-1:0] idx;

    assign req       = bus.mem_read | bus.mem_write;
    assign req_err   = (bus.data_adr[1:0] != 2'b00)
                    || (bus.data_adr[31:2] >= 30'(DEPTH))
                    || (bus.mem_read && bus.mem_write);
    assign idx       = adr_q[AW+1:2];
    assign in_range  = adr_q[31:2] < 30'(DEPTH);
    assign commit    = (state == BUSY) && (cnt == 4'd0);
    assign commit_wr = commit && (op_q == OP_WR) && in_range;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req) state_next = BUSY;
            BUSY:    if (cnt == 4'd0) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.mem_ready = (state == RESP);
        bus.data_out  = data_q;
        bus.mem_err   = err_q;
        fsm_state     = state;
    end

    // Request capture, wait-state counter, read data register and sticky error.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt     <= 4'd0;
            adr_q   <= 32'd0;
            wdata_q <= 32'd0;
            op_q    <= OP_RD;
            data_q  <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            if ((state == IDLE) && req) begin
                adr_q   <= bus.data_adr;
                wdata_q <= bus.data_in;
                op_q    <= bus.mem_write ? OP_WR : OP_RD;
                cnt     <= 4'(LATENCY - 1);
                if (req_err) err_q <= 1'b1;
            end else if ((state == BUSY) && (cnt != 4'd0)) begin
                cnt <= cnt - 4'd1;
            end
            if (commit && (op_q == OP_RD)) begin
                data_q <= in_range ? mem[idx] : 32'd0;
            end
        end
    end

    // The array has no reset; gating on rst keeps a reset during BUSY from committing.
    always_ff @(posedge clk) begin
        if (rst && commit_wr) begin
            mem[idx] <= wdata_q;
        end
    end

`ifdef MIN_TRACK_EN
    min_tracker #(
        .MIN_BASE  (MIN_BASE),
        .MIN_COUNT (MIN_COUNT)
    ) u_min_tracker (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (commit_wr),
        .wr_adr    (adr_q),
        .wr_data   (wdata_q),
        .min_value (min_value),
        .min_index (min_index)
    );
`else
    localparam logic [AW-1:0] RES_IDX = AW'(MIN_RES_ADR >> 2);
    localparam logic [AW-1:0] IDX_IDX = AW'((MIN_RES_ADR + 32'd4) >> 2);

    assign min_value = mem[RES_IDX];
    assign min_index = mem[IDX_IDX];
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed scenarios plus randomized
// traffic scored against a word-level memory model and an expected-read queue.
module tb_data_mem_responder;
  import mem_pkg::*;

  localparam int          DEPTH     = 1024;
  localparam int          LATENCY   = 2;
  localparam logic [31:0] MIN_BASE  = 32'd1000;
  localparam int          MIN_COUNT = 20;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] data;
  } wr_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  data_mem_responder_if bus();
  logic [31:0] min_value;
  logic [31:0] min_index;
  state_t      fsm_state;

  data_mem_responder #(
    .DEPTH   (DEPTH),
    .LATENCY (LATENCY)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .min_value (min_value),
    .min_index (min_index),
    .fsm_state (fsm_state)
  );

  // scoreboard state
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] ref_mem [int];
  logic        ref_err  = 1'b0;
  logic [31:0] exp_q [$];
  wr_t         win_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void model_min(output logic [31:0] v, output logic [31:0] ix);
    v  = 32'h7FFF_FFFF;
    ix = 32'd0;
    foreach (win_q[i]) begin
      if ($signed(win_q[i].data) < $signed(v)) begin
        v  = win_q[i].data;
        ix = (win_q[i].adr - MIN_BASE) >> 2;
      end
    end
  endfunction

  task automatic idle_inputs();
    bus.data_adr  = 32'd0;
    bus.data_in   = 32'd0;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
  endtask

  // driver: one full access, entered and left on a negedge with the DUT idle
  task automatic do_access(input logic [31:0] adr, input logic [31:0] wdata,
                           input logic rd, input logic wr, input string tag);
    int          cyc;
    int unsigned w;
    bit          oob;
    bit          known;
    w     = adr[31:2];
    oob   = (w >= DEPTH);
    known = 1'b0;
    if ((adr[1:0] != 2'b00) || oob || (rd && wr)) ref_err = 1'b1;
    if (wr) begin
      if (!oob) begin
        ref_mem[w] = wdata;
        if ((adr >= MIN_BASE) && (adr < MIN_BASE + 32'(4 * MIN_COUNT)))
          win_q.push_back('{adr: adr, data: wdata});
      end
    end else if (oob) begin
      known = 1'b1;
      exp_q.push_back(32'd0);
    end else if (ref_mem.exists(w)) begin
      known = 1'b1;
      exp_q.push_back(ref_mem[w]);
    end

    bus.data_adr  = adr;
    bus.data_in   = wdata;
    bus.mem_read  = rd;
    bus.mem_write = wr;
    cyc = 0;
    while ((bus.mem_ready !== 1'b1) && (cyc < 40)) begin
      @(negedge clk);
      cyc++;
    end
    idle_inputs();
    check({tag, "_latency"}, 32'(cyc - 1), 32'(LATENCY));
    if (cyc >= 40) begin
      if (known) void'(exp_q.pop_front());
    end else begin
      if (known) check({tag, "_rdata"}, bus.data_out, exp_q.pop_front());
      check({tag, "_err"}, 32'(bus.mem_err), 32'(ref_err));
      @(negedge clk);
      check({tag, "_pulse_len"}, 32'(bus.mem_ready), 32'd0);
    end
  endtask

  task automatic check_min(input string tag);
`ifdef MIN_TRACK_EN
    logic [31:0] v;
    logic [31:0] ix;
    model_min(v, ix);
    check({tag, "_min_value"}, min_value, v);
    check({tag, "_min_index"}, min_index, ix);
`else
    if (ref_mem.exists(500)) check({tag, "_min_value"}, min_value, ref_mem[500]);
    if (ref_mem.exists(501)) check({tag, "_min_index"}, min_index, ref_mem[501]);
`endif
  endtask

  initial begin
    int          kind;
    int          r;
    logic [31:0] word;
    logic [31:0] adr;
    int          pulses;

    idle_inputs();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_ready", 32'(bus.mem_ready), 32'd0);
    check("reset_data_out", bus.data_out, 32'd0);
    check("reset_err", 32'(bus.mem_err), 32'd0);
    check("reset_state", 32'(fsm_state), 32'(IDLE));
`ifdef MIN_TRACK_EN
    check("reset_min_value", min_value, 32'h7FFF_FFFF);
    check("reset_min_index", min_index, 32'd0);
`endif
    rst = 1'b1;
    @(negedge clk);

    // write then read back
    do_access(32'd1000, 32'd5, 1'b0, 1'b1, "t1_wr");
    do_access(32'd1000, 32'd0, 1'b1, 1'b0, "t1_rd");

    // out-of-range read, then error stays sticky
    do_access(32'(4 * DEPTH), 32'd0, 1'b1, 1'b0, "t2_oob_rd");
    do_access(32'd1000, 32'd0, 1'b1, 1'b0, "t2_sticky");

    // read and write together act as a write
    do_access(32'd8, 32'd7, 1'b1, 1'b1, "t3_both");
    do_access(32'd8, 32'd0, 1'b1, 1'b0, "t3_rd");

    // reset during BUSY aborts the pending write
    do_access(32'd1008, 32'h55, 1'b0, 1'b1, "t4_pre");
    do_access(32'd1004, 32'd9, 1'b0, 1'b1, "t4_wr");
    bus.data_adr  = 32'd1008;
    bus.data_in   = 32'hDEAD_BEEF;
    bus.mem_write = 1'b1;
    @(negedge clk);
    check("t4_busy", 32'(fsm_state), 32'(BUSY));
    rst = 1'b0;
    idle_inputs();
    @(negedge clk);
    check("t4_state_idle", 32'(fsm_state), 32'(IDLE));
    check("t4_err_cleared", 32'(bus.mem_err), 32'd0);
    rst = 1'b1;
    ref_err = 1'b0;
    win_q.delete();
    pulses = 0;
    repeat (LATENCY + 3) begin
      @(negedge clk);
      if (bus.mem_ready === 1'b1) pulses++;
    end
    check("t4_no_pulse", 32'(pulses), 32'd0);
    do_access(32'd1004, 32'd0, 1'b1, 1'b0, "t4_rd9");
    do_access(32'd1008, 32'd0, 1'b1, 1'b0, "t4_rd_unchanged");

`ifdef MIN_TRACK_EN
    // tracker over a 20-word array with a repeated minimum
    for (int i = 0; i < MIN_COUNT; i++) begin
      do_access(MIN_BASE + 32'(4 * i),
                ((i == 9) || (i == 15)) ? -32'sd3 : 32'($urandom_range(0, 1000)),
                1'b0, 1'b1, "t5_fill");
    end
    check("t5_min_value", min_value, -32'sd3);
    check("t5_min_index", min_index, 32'd9);
    do_access(32'd1036, 32'd100, 1'b0, 1'b1, "t5_raise");
    check("t5_min_value_kept", min_value, -32'sd3);
    check("t5_min_index_kept", min_index, 32'd9);
`else
    // software result words
    do_access(32'd2000, 32'd42, 1'b0, 1'b1, "t6_val");
    check("t6_min_value", min_value, 32'd42);
    do_access(32'd2004, 32'd7, 1'b0, 1'b1, "t6_idx");
    check("t6_min_value_kept", min_value, 32'd42);
    check("t6_min_index", min_index, 32'd7);
`endif

    // randomized traffic
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 99);
      if (r < 70)      word = 32'($urandom_range(240, 275));
      else if (r < 80) word = 32'($urandom_range(500, 501));
      else if (r < 90) word = 32'($urandom_range(0, 31));
      else if (r < 96) word = 32'(DEPTH + $urandom_range(0, 100));
      else             word = 32'h3FFF_FFFF;
      adr = {word[29:0], 2'b00};
      if ($urandom_range(0, 19) == 0) adr[1:0] = 2'($urandom_range(1, 3));
      kind = $urandom_range(0, 9);
      do_access(adr, $urandom, (kind == 0) || (kind > 4), kind <= 4, "rnd");
      check_min("rnd");
    end

    check("final_exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
